vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Parametrised single-clock VGA scanout engine.
- Generates programmable display timing and prefetches packed pixel words from the memory interface into a word FIFO.
- Unpacks pixels MSB-first and drives registered pixel, sync and blank outputs.
- Adds a pixel-enable strobe, test-pattern and solid-fill modes, FIFO underrun detection with frame-level recovery, and an underrun counter.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 11, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 31, vertical back porch (lines)
- PIX_W, 18, bits per pixel
- PPW, 2, pixels per memory word; MEM_W = PIX_W*PPW
- FIFO_DEPTH, 8, word FIFO entries (power of 2, >=2)
- HC_W, 10 / VC_W, 10, counter widths

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe; timing advances one pixel per cycle with pix_en=1
- frame_flag  in  1  memory busy (buffer swap); no new requests while 1
- mode  in  2  0=memory, 1=test pattern, 2/3=solid fill
- fill_color  in  PIX_W  pixel used for fill mode and underrun
- vga_flag  out  1  one-cycle request for next word
- vga_pixel  in  MEM_W  returned word
- done_vga  in  1  vga_pixel valid this cycle
- hcount  out  HC_W  current horizontal position
- vcount  out  VC_W  current line
- pixel_out  out  PIX_W  registered pixel
- hsync_b / vsync_b  out  1  active-low syncs, registered
- blank_b  out  1  1 in active region, registered
- underrun  out  1  sticky underrun flag
- underrun_count  out  16  saturating count of underrun frames

Behaviour:
- Reset (synchronous, active-high, when reset=1 at clock edge):
  - hcount, vcount, pixel_out, FIFO, fetch counter, sub-index, underrun, underrun_count cleared to 0.
  - hsync_b=1, vsync_b=1, blank_b=0, vga_flag=0, outstanding/discard flags cleared.
  - Reset mid-request: any later done_vga is ignored.
- Timing:
  - H_TOTAL = sum of H params; V_TOTAL = sum of V params.
  - On pix_en, hcount increments and wraps H_TOTAL-1 -> 0; vcount increments on that wrap and wraps V_TOTAL-1 -> 0.
  - Without pix_en, all timing state and outputs hold.
- Registered outputs for position (h,v) update on the edge ending the pix_en cycle in which hcount/vcount = (h,v); latency is 1 pix_en cycle.
  - blank_b = (h<H_ACTIVE && v<V_ACTIVE).
  - hsync_b=0 for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync_b=0 for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines).
  - pixel_out=0 when blank.
- Fetch:
  - WPF = H_ACTIVE*V_ACTIVE/PPW.
  - vga_flag=1 for one cycle when all of the following hold:
    - mode==0
    - !frame_flag
    - no request outstanding
    - fifo_count < FIFO_DEPTH
    - fetch_cnt < WPF
    - !reset
  - Issuing a request sets outstanding and increments fetch_cnt.
  - done_vga with outstanding: push the word unless discard is set, then clear outstanding and discard.
  - done_vga with no outstanding request is ignored.
  - At most one request is outstanding, so the FIFO never overflows.
- Consume (active pixel with pix_en):
  - mode 0, no frame stall: pixel_out = head word slice [(PPW-1-sub)*PIX_W +: PIX_W]. sub increments; on sub==PPW-1 the head is popped and sub returns to 0. A pop and a push in the same cycle are both honoured.
  - mode 0, FIFO empty: set frame stall, set underrun, output fill_color for the rest of the active frame.
  - mode 1: pixel_out = (h[5]^v[5]) ? all-ones : 0.
  - mode 2/3: pixel_out = fill_color.
  - Mode changes take effect on the next pixel.
- Frame resync: on the pix_en cycle with h==0 && v==V_ACTIVE:
  - FIFO flushed, fetch_cnt=0, sub=0.
  - If a request is outstanding, discard is set.
  - If the frame stalled, underrun_count increments (saturating at 0xFFFF); stall is then cleared.
  - Prefetch for the next frame starts in vblank.

Test Plan:
All scenarios use H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, PIX_W=8, PPW=2, FIFO_DEPTH=4, pix_en=1.
- Reset and timing: after reset, hsync_b low exactly for hcount 10-11 (delayed 1 cycle), vsync_b low for vcount 5, blank_b high for 32 pixels/frame, frame length 98 cycles.
- Memory mode, responder returns words 0xAABB, 0xCCDD ... with done_vga 2 cycles after vga_flag -> pixel_out sequence AA, BB, CC, DD; exactly 16 requests per frame; vga_flag never asserted with 4 words queued.
- frame_flag held high through vblank and the first line -> no vga_flag, underrun=1, fill_color 0x5A on all remaining active pixels, underrun_count=1; next frame clean, count stays 1.
- Reset asserted with a request outstanding; done_vga arrives after reset is released -> FIFO remains empty, no push.
- mode=1 -> pixel_out 0 everywhere (h,v<32); mode=2 with fill 0x3C -> 0x3C on active pixels, 0 on blank, vga_flag stays 0.
- pix_en toggled 1/0 -> outputs and counters hold on 0 cycles; sequence identical to scenario 2 at half rate.

Source files
------------

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - memory fetch handshake between the scanout engine and the frame buffer
interface vga_scanout_if #(
    parameter int MEM_W = 36
);
    logic             vga_flag;
    logic [MEM_W-1:0] vga_pixel;
    logic             done_vga;
    logic             frame_flag;

    modport master (output vga_flag, input vga_pixel, input done_vga, input frame_flag);
    modport slave  (input vga_flag, output vga_pixel, output done_vga, output frame_flag);
endinterface

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator with prefetching word FIFO and MSB-first pixel unpacker
module vga_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 11,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 31,
    parameter int PIX_W      = 18,
    parameter int PPW        = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int HC_W       = 10,
    parameter int VC_W       = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_en,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] fill_color,
    vga_scanout_if.master    mem,
    output logic [HC_W-1:0]  hcount,
    output logic [VC_W-1:0]  vcount,
    output logic [PIX_W-1:0] pixel_out,
    output logic             hsync_b,
    output logic             vsync_b,
    output logic             blank_b,
    output logic             underrun,
    output logic [15:0]      underrun_count
);
    localparam int MEM_W    = PIX_W * PPW;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int WPF      = H_ACTIVE * V_ACTIVE / PPW;
    localparam int FC_W     = $clog2(WPF + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int SUB_W    = (PPW > 1) ? $clog2(PPW) : 1;

    logic [MEM_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fifo_count;
    logic [FC_W-1:0]  fetch_cnt;
    logic [SUB_W-1:0] sub;
    logic             outstanding, discard, stall;

    logic             active, resync, fifo_empty, issue, accept, push, consume, pop;
    logic             in_hsync, in_vsync, starve;
    logic [MEM_W-1:0] head;
    logic [PIX_W-1:0] head_pix, next_pix;

    // decode position, fetch eligibility and the pixel to present for this position
    always_comb begin
        active     = (hcount < HC_W'(H_ACTIVE)) && (vcount < VC_W'(V_ACTIVE));
        in_hsync   = (hcount >= HC_W'(HS_START)) && (hcount < HC_W'(HS_END));
        in_vsync   = (vcount >= VC_W'(VS_START)) && (vcount < VC_W'(VS_END));
        resync     = pix_en && (hcount == '0) && (vcount == VC_W'(V_ACTIVE));
        fifo_empty = (fifo_count == '0);
        issue      = !reset && (mode == 2'd0) && !mem.frame_flag && !outstanding
                     && (fifo_count < (AW+1)'(FIFO_DEPTH)) && (fetch_cnt < FC_W'(WPF));
        accept     = !reset && mem.done_vga && outstanding;
        // a word landing on the resync cycle belongs to the frame being abandoned
        push       = accept && !discard && !resync;
        consume    = pix_en && active && (mode == 2'd0) && !stall && !fifo_empty;
        pop        = consume && (sub == SUB_W'(PPW - 1));
        starve     = pix_en && active && (mode == 2'd0) && !stall && fifo_empty;
        head       = fifo_mem[rd_ptr];
        head_pix   = PIX_W'(head >> (PIX_W * (PPW - 1 - int'(sub))));
        next_pix   = '0;
        if (active) begin
            case (mode)
                2'd0:    next_pix = (stall || fifo_empty) ? fill_color : head_pix;
                2'd1:    next_pix = (hcount[5] ^ vcount[5]) ? {PIX_W{1'b1}} : '0;
                default: next_pix = fill_color;
            endcase
        end
    end

    assign mem.vga_flag = issue;

    // raster counters and registered video outputs, advancing only on the pixel strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            hcount    <= '0;
            vcount    <= '0;
            pixel_out <= '0;
            hsync_b   <= 1'b1;
            vsync_b   <= 1'b1;
            blank_b   <= 1'b0;
        end else if (pix_en) begin
            blank_b   <= active;
            hsync_b   <= !in_hsync;
            vsync_b   <= !in_vsync;
            pixel_out <= next_pix;
            if (hcount == HC_W'(H_TOTAL - 1)) begin
                hcount <= '0;
                vcount <= (vcount == VC_W'(V_TOTAL - 1)) ? '0 : vcount + VC_W'(1);
            end else begin
                hcount <= hcount + HC_W'(1);
            end
        end
    end

    // word storage; validity is tracked by the pointers so contents need no reset
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem.vga_pixel;
        end
    end

    // fetch bookkeeping, FIFO pointers, unpack index and underrun tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            fetch_cnt      <= '0;
            sub            <= '0;
            outstanding    <= 1'b0;
            discard        <= 1'b0;
            stall          <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else if (resync) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            sub         <= '0;
            fetch_cnt   <= issue ? FC_W'(1) : '0;
            outstanding <= issue || (outstanding && !mem.done_vga);
            discard     <= outstanding && !mem.done_vga;
            stall       <= 1'b0;
            if (stall && (underrun_count != 16'hFFFF)) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            if (issue) begin
                fetch_cnt   <= fetch_cnt + FC_W'(1);
                outstanding <= 1'b1;
            end else if (accept) begin
                outstanding <= 1'b0;
            end
            if (accept) begin
                discard <= 1'b0;
            end
            if (consume) begin
                sub <= pop ? '0 : sub + SUB_W'(1);
            end
            if (starve) begin
                stall    <= 1'b1;
                underrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard bench for vga_scanout with a frame-level reference model
module tb_vga_scanout;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int PW = 8, PPW = 2, FD = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int WPF = HA * VA / PPW;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic [7:0]  pix;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        ur;
        logic [15:0] uc;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset, pix_en;
    logic [1:0]  mode;
    logic [7:0]  fill_color;
    logic [9:0]  hcount, vcount;
    logic [7:0]  pixel_out;
    logic        hsync_b, vsync_b, blank_b, underrun;
    logic [15:0] underrun_count;

    vga_scanout_if #(.MEM_W(16)) mem();

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_W(PW), .PPW(PPW), .FIFO_DEPTH(FD), .HC_W(10), .VC_W(10)
    ) dut (
        .clock(clock), .reset(reset), .pix_en(pix_en), .mode(mode),
        .fill_color(fill_color), .mem(mem), .hcount(hcount), .vcount(vcount),
        .pixel_out(pixel_out), .hsync_b(hsync_b), .vsync_b(vsync_b),
        .blank_b(blank_b), .underrun(underrun), .underrun_count(underrun_count)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail = 0;
    rec_t exp_q[$];
    rec_t mon_e, mon_a;

    // stimulus knobs
    logic       g_rst = 1'b1, g_ff = 1'b0, g_half = 1'b0;
    logic [1:0] g_mode = 2'd2;
    logic [7:0] g_fill = 8'h3C;
    int         g_lat_min = 1, g_lat_max = 3;

    // reference model state
    int          cyc = 0;
    int          mh = 0, mv = 0;
    rec_t        cur;
    logic [15:0] words[$];
    int          popped = 0, req_epoch = 0, epoch = 0;
    bit          starved = 0, all_m0 = 0;
    logic        exp_ur = 1'b0;
    logic [15:0] exp_uc = 16'd0;
    bit          rp = 0, rkill = 0;
    int          rcnt = 0, repoch = 0;
    logic [15:0] rword = 16'd0;

    task automatic model_step();
        logic        exp_flag, act;
        rec_t        n;
        int          k, widx, ph, pv;
        logic [15:0] w;
        exp_flag = !reset && (mode == 2'd0) && !mem.frame_flag && !(rp && !rkill)
                   && ((words.size() - popped) < FD) && (req_epoch < WPF);
        n_checks++;
        if (mem.vga_flag !== exp_flag) begin
            n_fail++;
            $display("FAIL vga_flag: got %b expected %b at h=%0d v=%0d queued=%0d", mem.vga_flag, exp_flag, mh, mv, words.size() - popped);
        end
        n = cur;
        ph = mh;
        pv = mv;
        if (reset) begin
            n = '{h:10'd0, v:10'd0, pix:8'd0, hs:1'b1, vs:1'b1, bl:1'b0, ur:1'b0, uc:16'd0};
            mh = 0;
            mv = 0;
        end else if (pix_en) begin
            act  = (mh < HA) && (mv < VA);
            n.bl = act;
            n.hs = !((mh >= HA + HF) && (mh < HA + HF + HS));
            n.vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
            if (!act) n.pix = 8'h00;
            else if (mode == 2'd1) n.pix = (((mh / 32) + (mv / 32)) % 2 == 1) ? 8'hFF : 8'h00;
            else if (mode != 2'd0) n.pix = fill_color;
            else begin
                k = mv * HA + mh;
                widx = k / PPW;
                if (!starved && (k % PPW == 0) && (widx >= words.size())) begin
                    starved = 1;
                    exp_ur = 1'b1;
                end
                if (starved) n.pix = fill_color;
                else begin
                    w = words[widx];
                    n.pix = w[15 - PW * (k % PPW) -: 8];
                    if (k % PPW == PPW - 1) popped++;
                end
            end
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
            n.h = 10'(mh);
            n.v = 10'(mv);
        end
        if (reset) begin
            words.delete();
            popped = 0; req_epoch = 0; starved = 0; all_m0 = 0;
            exp_ur = 1'b0; exp_uc = 16'd0;
            epoch++;
            rkill = rp;
        end else if (pix_en && ph == 0 && pv == VA) begin
            if (all_m0 && !starved) begin
                n_checks++;
                if (req_epoch != WPF) begin
                    n_fail++;
                    $display("FAIL words_per_frame: got %0d expected %0d", req_epoch, WPF);
                end
            end
            if (starved && exp_uc != 16'hFFFF) exp_uc++;
            starved = 0;
            words.delete();
            popped = 0; req_epoch = 0; all_m0 = 1;
            epoch++;
        end
        all_m0 = all_m0 && (mode == 2'd0);
        if (mem.done_vga) begin
            if (!reset && !rkill && repoch == epoch) words.push_back(mem.vga_pixel);
            rp = 0;
            rkill = 0;
        end else if (rp) begin
            rcnt--;
        end
        if (mem.vga_flag) begin
            rp = 1; rkill = 0;
            rcnt = int'($urandom_range(g_lat_max, g_lat_min)) - 1;
            rword = 16'($urandom);
            repoch = epoch;
            req_epoch++;
        end
        n.ur = exp_ur;
        n.uc = exp_uc;
        cur = n;
        exp_q.push_back(n);
    endtask

    task automatic cycle();
        reset = g_rst;
        mode = g_mode;
        fill_color = g_fill;
        mem.frame_flag = g_ff;
        pix_en = g_half ? (cyc % 2 == 0) : 1'b1;
        if (rp && rcnt == 0) begin
            mem.done_vga = 1'b1;
            mem.vga_pixel = rword;
        end else begin
            mem.done_vga = 1'b0;
            mem.vga_pixel = 16'($urandom);
        end
        @(negedge clock);
        model_step();
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic run_to(input int th, input int tv);
        int guard;
        guard = 0;
        while (mh == th && mv == tv && guard < 1000) begin cycle(); guard++; end
        while (!(mh == th && mv == tv) && guard < 1000) begin cycle(); guard++; end
        if (guard >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_to_timeout: got h=%0d v=%0d expected h=%0d v=%0d", mh, mv, th, tv);
        end
    endtask

    // monitor: compares registered outputs against the scoreboard after every edge
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = '{h:hcount, v:vcount, pix:pixel_out, hs:hsync_b, vs:vsync_b, bl:blank_b, ur:underrun, uc:underrun_count};
                n_checks++;
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL outputs: got h=%0d v=%0d pix=%h hs=%b vs=%b bl=%b ur=%b uc=%0d expected h=%0d v=%0d pix=%h hs=%b vs=%b bl=%b ur=%b uc=%0d",
                             mon_a.h, mon_a.v, mon_a.pix, mon_a.hs, mon_a.vs, mon_a.bl, mon_a.ur, mon_a.uc,
                             mon_e.h, mon_e.v, mon_e.pix, mon_e.hs, mon_e.vs, mon_e.bl, mon_e.ur, mon_e.uc);
                end
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1; pix_en = 1'b1; mode = 2'd2; fill_color = 8'h3C;
        mem.frame_flag = 1'b0; mem.done_vga = 1'b0; mem.vga_pixel = 16'h0;
        @(posedge clock);
        #1;
        repeat (3) cycle();
        g_rst = 1'b0;
        run_to(0, VA);
        g_mode = 2'd0;
        repeat (3) run_to(0, VA);
        g_mode = 2'd1;
        run_to(0, VA);
        g_mode = 2'd2;
        g_fill = 8'($urandom);
        run_to(0, VA);
        g_mode = 2'd0;
        g_fill = 8'h5A;
        g_ff = 1'b1;
        run_to(0, 1);
        g_ff = 1'b0;
        repeat (3) run_to(0, VA);
        g_half = 1'b1;
        repeat (2) run_to(0, VA);
        g_half = 1'b0;
        g_lat_min = 3;
        g_lat_max = 4;
        guard = 0;
        while (!(rp && !rkill) && guard < 200) begin cycle(); guard++; end
        n_checks++;
        if (!(rp && !rkill)) begin
            n_fail++;
            $display("FAIL request_before_reset: got none expected a request within 200 cycles");
        end
        g_rst = 1'b1;
        g_ff = 1'b1;
        cycle();
        g_rst = 1'b0;
        repeat (6) cycle();
        g_ff = 1'b0;
        g_lat_min = 1;
        g_lat_max = 3;
        repeat (3) run_to(0, VA);
        repeat (3) cycle();
        @(posedge clock);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
